// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the instruction-fetch and data ports.
// Data wins contention, but a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
    typedef enum logic [1:0] {RSP_NONE, RSP_I, RSP_D, RSP_ERR} resp_t;

    state_t     state;
    state_t     next_state;
    resp_t      resp_kind;
    logic [3:0] starve_cnt;
    logic       kill_lat;
    logic       fetch_live;
    logic       starve_full;
    logic       grant_i;
    logic       grant_d;
    logic       reject_i;

    // A killed fetch is invisible to arbitration for that cycle.
    assign fetch_live  = if_req && !if_kill;
    assign starve_full = (starve_cnt == STARVE_LIM);

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        reject_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(fetch_live && starve_full)) begin
                    grant_d    = 1'b1;
                    next_state = GNT_D;
                end else if (fetch_live) begin
                    if (if_addr[1:0] != 2'b00) begin
                        reject_i   = 1'b1;
                        next_state = RESP;
                    end else begin
                        grant_i    = 1'b1;
                        next_state = GNT_I;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_kind  <= RSP_NONE;
            starve_cnt <= 4'd0;
            kill_lat   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_size   <= 2'b00;
            if_rdata   <= 32'd0;
            d_rdata    <= 32'd0;
            owner      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_size  <= d_size;
                        owner     <= 1'b1;
                        resp_kind <= RSP_D;
                        if (if_req && !starve_full) starve_cnt <= starve_cnt + 4'd1;
                    end else if (grant_i) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= 32'd0;
                        mem_size   <= SIZE_WORD;
                        owner      <= 1'b0;
                        resp_kind  <= RSP_I;
                        starve_cnt <= 4'd0;
                    end else if (reject_i) begin
                        resp_kind <= RSP_ERR;
                    end
                end
                GNT_I, GNT_D: begin
                    // The kill only suppresses the ack; the memory side always completes.
                    if (state == GNT_I && if_kill) kill_lat <= 1'b1;
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (state == GNT_I) if_rdata <= mem_rdata;
                        else                d_rdata  <= mem_rdata;
                    end
                end
                RESP:    kill_lat <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign if_ack = (state == RESP) && (resp_kind == RSP_I) && !kill_lat && !if_kill;
    assign if_err = (state == RESP) && (resp_kind == RSP_ERR);
    assign d_ack  = (state == RESP) && (resp_kind == RSP_D);

endmodule
